// File: rtl/mac_pe_sched_pkg.sv
// Shared types and widths for the MAC processing-element scheduler.
package mac_pe_sched_pkg;

  localparam int W_WEIGHT       = 4;
  localparam int W_ACT          = 8;
  localparam int W_RES          = 17;
  localparam int ACC_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_ACC    = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

endpackage

// File: rtl/mac_pe_sched.sv
// Job scheduler for one MAC processing element: clears the PE, streams
// weight/activation pairs into it, runs the accumulate phase, then returns
// the PE result over a valid/ready handshake.
module mac_pe_sched
  import mac_pe_sched_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LEN_W-1:0]           cfg_len,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [W_WEIGHT-1:0] in_weight,
  input  logic signed [W_ACT-1:0]    in_act,
  output logic                       pe_en,
  output logic                       pe_data_valid,
  output logic signed [W_WEIGHT-1:0] pe_weight,
  output logic signed [W_ACT-1:0]    pe_activation,
  output logic                       pe_reset,
  output logic                       pe_acc,
  input  logic                       pe_output_valid,
  input  logic signed [W_RES-1:0]    pe_output_result,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [W_RES-1:0]    res_data
);

  localparam int ACC_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  state_t                   state_q;
  state_t                   state_d;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt_q;
  logic [ACC_W-1:0]         acc_cnt_q;
  logic signed [W_RES-1:0]  res_data_p0;
  logic                     transfer;
  logic                     acc_last;

  assign transfer      = in_valid & in_ready;
  assign acc_last      = (acc_cnt_q == ACC_W'(ACC_CYCLES - 1));
  assign pe_en         = ~rst;
  assign pe_data_valid = transfer;
  assign pe_weight     = in_weight;
  assign pe_activation = in_act;
  assign res_data      = res_data_p0;

  // Next-state and control outputs; all handshake/PE strobes forced low during reset
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    in_ready  = 1'b0;
    pe_reset  = 1'b0;
    pe_acc    = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        pe_reset = 1'b1;
        state_d  = (len_q == '0) ? S_ACC : S_STREAM;
      end
      S_STREAM: begin
        in_ready = (cnt_q < len_q);
        if (in_valid && (cnt_q < len_q) && ((cnt_q + LEN_W'(1)) == len_q))
          state_d = S_ACC;
      end
      S_ACC: begin
        pe_acc = (acc_cnt_q == '0);
        if (acc_last) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pe_output_valid) state_d = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      busy      = 1'b0;
      in_ready  = 1'b0;
      pe_reset  = 1'b0;
      pe_acc    = 1'b0;
      res_valid = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Job length latch, pair counter and accumulate-phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      acc_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        len_q <= cfg_len;
        cnt_q <= '0;
      end else if (transfer) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (state_q == S_ACC) acc_cnt_q <= acc_cnt_q + ACC_W'(1);
      else                  acc_cnt_q <= '0;
    end
  end

  // Result capture: empty jobs always report zero regardless of PE contents
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_p0 <= '0;
    end else if (state_q == S_WAIT && pe_output_valid) begin
      res_data_p0 <= (len_q == '0) ? '0 : pe_output_result;
    end
  end

endmodule

// File: tb/tb_mac_pe_sched.sv
module tb_mac_pe_sched;
  import mac_pe_sched_pkg::*;

  localparam int LEN_W = 8;
  localparam int ACC   = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [LEN_W-1:0]           cfg_len;
  logic                       busy;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [W_WEIGHT-1:0] in_weight;
  logic signed [W_ACT-1:0]    in_act;
  logic                       pe_en;
  logic                       pe_data_valid;
  logic signed [W_WEIGHT-1:0] pe_weight;
  logic signed [W_ACT-1:0]    pe_activation;
  logic                       pe_reset;
  logic                       pe_acc;
  logic                       pe_output_valid;
  logic signed [W_RES-1:0]    pe_output_result;
  logic                       res_valid;
  logic                       res_ready;
  logic signed [W_RES-1:0]    res_data;

  always #5 clk = ~clk;

  mac_pe_sched #(.LEN_W(LEN_W), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_weight(in_weight), .in_act(in_act),
    .pe_en(pe_en), .pe_data_valid(pe_data_valid), .pe_weight(pe_weight),
    .pe_activation(pe_activation), .pe_reset(pe_reset), .pe_acc(pe_acc),
    .pe_output_valid(pe_output_valid), .pe_output_result(pe_output_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, $signed(act), act, $signed(exp), exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Simple PE stand-in: sums products, cleared by pe_reset, result valid
  // for one cycle ACC+pe_extra cycles after the accumulate pulse.
  int                      pe_cnt   = 0;
  int                      pe_extra = 0;
  logic signed [W_RES-1:0] pe_sum   = '0;

  always @(posedge clk) begin
    if (pe_en) begin
      if (pe_reset) begin
        pe_sum <= '0;
        pe_cnt <= 0;
      end else begin
        if (pe_data_valid) pe_sum <= pe_sum + W_RES'(int'(pe_weight) * int'(pe_activation));
        if (pe_acc)          pe_cnt <= ACC + pe_extra;
        else if (pe_cnt > 0) pe_cnt <= pe_cnt - 1;
      end
    end
  end
  assign pe_output_valid  = (pe_cnt == 1);
  assign pe_output_result = pe_sum;

  // Operand source: presents queued pairs, each preceded by its own gap.
  typedef struct {
    int w;
    int a;
    int gap;
  } pair_t;
  pair_t src_q[$];
  bit    xfer_seen  = 1'b0;
  int    gap_left   = 0;
  bit    gap_loaded = 1'b0;

  initial begin : source
    in_valid  = 1'b0;
    in_weight = '0;
    in_act    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (xfer_seen && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap_loaded = 1'b0;
      end
      if (src_q.size() > 0) begin
        if (!gap_loaded) begin
          gap_left   = src_q[0].gap;
          gap_loaded = 1'b1;
        end
        if (gap_left > 0) begin
          gap_left--;
          in_valid  = 1'b0;
          in_weight = W_WEIGHT'($urandom);
          in_act    = W_ACT'($urandom);
        end else begin
          in_valid  = 1'b1;
          in_weight = W_WEIGHT'(src_q[0].w);
          in_act    = W_ACT'(src_q[0].a);
        end
      end else begin
        gap_loaded = 1'b0;
        in_valid   = 1'b0;
        in_weight  = W_WEIGHT'($urandom);
        in_act     = W_ACT'($urandom);
      end
    end
  end

  // Reference model: one job timeline, described by the cycle it was
  // accepted, transfers seen, the cycle ACC must begin and the cycle the
  // PE result appeared.
  bit                      m_active   = 1'b0;
  int                      m_t0       = 0;
  int                      m_len      = 0;
  int                      m_xfers    = 0;
  int                      m_acc_at   = -1;
  int                      m_pov      = -1;
  int                      m_sum      = 0;
  logic signed [W_RES-1:0] m_last_res = '0;
  int                      done_cnt   = 0;
  int                      first_rv   = -1;
  int                      hs_data    = 0;
  int                      acc_pulses = 0;
  int                      ir_cycles  = 0;
  logic                    e_ir, e_clr, e_acc, e_rv;
  logic signed [W_RES-1:0] e_data;

  always @(negedge clk) begin
    xfer_seen = in_valid & in_ready;
    chk("pe_en", 32'(pe_en), 32'(!rst));
    chk("pe_weight_pass", 32'(pe_weight), 32'(in_weight));
    chk("pe_act_pass", 32'(pe_activation), 32'(in_act));
    if (!rst) begin
      e_ir   = m_active && (cyc >= m_t0 + 2) && (m_xfers < m_len) && (m_acc_at < 0);
      e_clr  = m_active && (cyc == m_t0 + 1);
      e_acc  = m_active && (cyc == m_acc_at);
      e_rv   = m_active && (m_pov >= 0) && (cyc > m_pov);
      e_data = e_rv ? W_RES'(m_sum) : m_last_res;
      chk("busy", 32'(busy), 32'(m_active));
      chk("in_ready", 32'(in_ready), 32'(e_ir));
      chk("pe_data_valid", 32'(pe_data_valid), 32'(e_ir & in_valid));
      chk("pe_reset", 32'(pe_reset), 32'(e_clr));
      chk("pe_acc", 32'(pe_acc), 32'(e_acc));
      chk("res_valid", 32'(res_valid), 32'(e_rv));
      chk("res_data", 32'(res_data), 32'(e_data));
      chk("strobe_exclusive", 32'((pe_reset & pe_acc) | (pe_reset & pe_data_valid) |
                                  (pe_acc & pe_data_valid)), 32'(0));
      if (pe_acc)   acc_pulses++;
      if (in_ready) ir_cycles++;
      if (res_valid && first_rv < 0) first_rv = cyc;
      if (m_active) begin
        if (e_ir && in_valid) begin
          m_sum += int'(in_weight) * int'(in_act);
          m_xfers++;
          if (m_xfers == m_len) m_acc_at = cyc + 1;
        end
        if (m_acc_at >= 0 && m_pov < 0 && cyc >= m_acc_at + ACC && pe_output_valid)
          m_pov = cyc;
        if (e_rv && res_ready) begin
          hs_data    = int'(res_data);
          m_last_res = W_RES'(m_sum);
          m_active   = 1'b0;
          chk("pe_acc_pulses_per_job", 32'(acc_pulses), 32'(1));
          done_cnt++;
        end
      end else if (start) begin
        m_active   = 1'b1;
        m_t0       = cyc;
        m_len      = int'(cfg_len);
        m_xfers    = 0;
        m_sum      = 0;
        m_pov      = -1;
        m_acc_at   = (m_len == 0) ? cyc + 2 : -1;
        acc_pulses = 0;
        ir_cycles  = 0;
        first_rv   = -1;
      end
    end else begin
      m_active   = 1'b0;
      m_last_res = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int w, input int a, input int g);
    pair_t p;
    p.w   = w;
    p.a   = a;
    p.gap = g;
    src_q.push_back(p);
  endtask

  // Start a job on already-queued pairs, answer the result handshake after
  // 'hold' cycles of res_valid, optionally spraying ignored start pulses.
  task automatic run_job(input int len, input int extra, input int hold, input bit noise,
                         output int lat, output int data);
    int d0, t, cnt, rv_cnt;
    pe_extra = extra;
    d0       = done_cnt;
    cfg_len  = LEN_W'(len);
    start    = 1'b1;
    t        = cyc;
    step();
    start   = 1'b0;
    cfg_len = LEN_W'($urandom);
    cnt     = 0;
    rv_cnt  = 0;
    while (done_cnt == d0 && cnt < 400) begin
      start = 1'b0;
      if (noise && $urandom_range(0, 3) == 0) begin
        start   = 1'b1;
        cfg_len = LEN_W'($urandom);
      end
      res_ready = 1'b0;
      if (res_valid) begin
        res_ready = (rv_cnt >= hold);
        rv_cnt++;
      end
      step();
      cnt++;
    end
    start     = 1'b0;
    res_ready = 1'b0;
    if (done_cnt == d0) begin
      chk("job_timeout", 32'(cnt), 32'(0));
      src_q.delete();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
    end
    lat  = first_rv - t;
    data = hs_data;
  endtask

  initial begin : main
    int lat, data, esum, len, w, a, t, d0;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_len   = '0;
    res_ready = 1'b0;
    step();
    chk("reset_pe_en_low", 32'(pe_en), 32'(0));
    step();
    rst = 1'b0;
    step();
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(0));
    chk("reset_res_valid", 32'(res_valid), 32'(0));
    chk("reset_res_data", 32'(res_data), 32'(0));
    chk("reset_pe_en_high", 32'(pe_en), 32'(1));

    // back-to-back four pairs
    push(1, 10, 0); push(2, 10, 0); push(3, 10, 0); push(4, 10, 0);
    run_job(4, 0, 0, 1'b0, lat, data);
    chk("len4_data", 32'(data), 32'(100));
    chk("len4_latency", 32'(lat), 32'(15));

    // three-cycle gap between two pairs
    push(-8, 5, 0); push(7, -3, 3);
    run_job(2, 0, 0, 1'b0, lat, data);
    chk("gap_data", 32'(data), 32'(-61));
    chk("gap_latency", 32'(lat), 32'(16));

    // empty job
    run_job(0, 0, 0, 1'b0, lat, data);
    chk("len0_data", 32'(data), 32'(0));
    chk("len0_latency", 32'(lat), 32'(11));
    chk("len0_in_ready_never", 32'(ir_cycles), 32'(0));

    // back-pressure on the result plus ignored start pulses
    push(5, -7, 0); push(-2, 20, 0); push(7, 127, 0);
    run_job(3, 0, 5, 1'b1, lat, data);
    chk("hold_data", 32'(data), 32'(814));
    chk("hold_latency", 32'(lat), 32'(14));

    // reset during the third accumulate cycle, then a fresh one-pair job
    d0 = done_cnt;
    push(7, 100, 0); push(-8, -128, 0); push(6, 50, 0); push(5, 77, 0);
    cfg_len = LEN_W'(4);
    start   = 1'b1;
    t       = cyc;
    step();
    start = 1'b0;
    while (cyc < t + 8) step();
    chk("abort_in_acc", 32'(busy), 32'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_idle", 32'(busy), 32'(0));
    chk("abort_res_data_cleared", 32'(res_data), 32'(0));
    repeat (3) step();
    chk("abort_no_result", 32'(done_cnt), 32'(d0));
    chk("abort_res_valid_low", 32'(res_valid), 32'(0));
    push(3, 4, 0);
    run_job(1, 0, 0, 1'b0, lat, data);
    chk("after_abort_data", 32'(data), 32'(12));
    chk("after_abort_latency", 32'(lat), 32'(12));

    // randomized jobs
    for (int j = 0; j < 30; j++) begin
      len  = $urandom_range(0, 10);
      esum = 0;
      for (int i = 0; i < len; i++) begin
        w = int'($urandom_range(0, 15)) - 8;
        a = int'($urandom_range(0, 255)) - 128;
        esum += w * a;
        push(w, a, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
      end
      run_job(len, $urandom_range(0, 3), $urandom_range(0, 3), 1'(j % 2), lat, data);
      chk("random_job_data", 32'(data), 32'(esum));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
